// File: rtl/id_ex_reg.sv
// id_ex_reg: ID->EX pipeline register of the pipelined MIPS core.
// Selects the EX immediate from the extender outputs and latches it with
// register data, destination and control. Hazard unit can hold (stall) or
// bubble (flush) the stage. A saturating counter tracks stalled cycles.
// Optional feature macro: ID_EX_BRANCH_TARGET_EN. When it is defined, the
// branch target adder is built; otherwise ex_br_target is tied to 0.
module id_ex_reg #(
   parameter int CTRL_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [31:0]       id_pc,
   input  logic [31:0]       ZeroExt5_in,
   input  logic [31:0]       ZeroExt16_in,
   input  logic [31:0]       SignExt16_in,
   input  logic [31:0]       SignExt18_in,
   input  logic [1:0]        imm_sel,
   input  logic [31:0]       rs_data,
   input  logic [31:0]       rt_data,
   input  logic [4:0]        rd_addr,
   input  logic              wb_en,
   input  logic [CTRL_W-1:0] ctrl,
   output logic              ex_valid,
   output logic [31:0]       ex_pc,
   output logic [31:0]       ex_imm,
   output logic [31:0]       ex_rs_data,
   output logic [31:0]       ex_rt_data,
   output logic [4:0]        ex_rd_addr,
   output logic              ex_wb_en,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [31:0]       ex_br_target,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [31:0] imm_mux;

   // Immediate select: pure selection among the extender outputs.
   always_comb begin
      imm_mux = ZeroExt5_in;
      case (imm_sel)
         2'b00:   imm_mux = ZeroExt5_in;
         2'b01:   imm_mux = ZeroExt16_in;
         2'b10:   imm_mux = SignExt16_in;
         default: imm_mux = SignExt18_in;
      endcase
   end

   // Stage register: rst > flush > stall > load. Bubbles carry all zeros.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         ex_valid   <= 1'b0;
         ex_pc      <= 32'd0;
         ex_imm     <= 32'd0;
         ex_rs_data <= 32'd0;
         ex_rt_data <= 32'd0;
         ex_rd_addr <= 5'd0;
         ex_wb_en   <= 1'b0;
         ex_ctrl    <= '0;
      end else if (!stall) begin
         ex_valid   <= id_valid;
         ex_pc      <= id_pc;
         ex_imm     <= imm_mux;
         ex_rs_data <= rs_data;
         ex_rt_data <= rt_data;
         ex_rd_addr <= rd_addr;
         ex_wb_en   <= wb_en & id_valid;
         ex_ctrl    <= id_valid ? ctrl : '0;
      end
   end

   // Stall counter: counts held edges only (flush overrides stall), saturates.
   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= '0;
      else if (stall && !flush && (stall_cnt != CNT_MAX))
         stall_cnt <= stall_cnt + CNT_ONE;
   end

`ifdef ID_EX_BRANCH_TARGET_EN
   logic [31:0] br_sum;
   assign br_sum = id_pc + 32'd4 + SignExt18_in;

   // Branch target register follows the same hold/bubble rules as the stage.
   always_ff @(posedge clk) begin
      if (rst || flush)
         ex_br_target <= 32'd0;
      else if (!stall)
         ex_br_target <= br_sum;
   end
`else
   assign ex_br_target = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: directed, table-driven bench for id_ex_reg plus hand-written
// multi-cycle sequences (stall hold, reset mid-stall, counter saturation).
module tb_id_ex_reg;

`ifdef ID_EX_BRANCH_TARGET_EN
   localparam bit BR_EN = 1'b1;
`else
   localparam bit BR_EN = 1'b0;
`endif

   typedef struct {
      logic        stall, flush, id_valid, wb_en;
      logic [1:0]  imm_sel;
      logic [31:0] id_pc, ze5, ze16, se16, se18, rs, rt;
      logic [4:0]  rd;
      logic [15:0] ctrl;
   } in_t;

   typedef struct {
      logic        valid, wb;
      logic [31:0] pc, imm, rs, rt;
      logic [4:0]  rd;
      logic [15:0] ctrl;
      logic [31:0] br;
      logic [15:0] cnt;
   } out_t;

   typedef struct {
      in_t  i;
      out_t o;
   } vec_t;

   logic clk = 1'b0;
   logic rst, stall, flush, id_valid, wb_en;
   logic [1:0]  imm_sel;
   logic [31:0] id_pc, ze5, ze16, se16, se18, rs_data, rt_data;
   logic [4:0]  rd_addr;
   logic [15:0] ctrl;

   logic        ex_valid, ex_wb_en;
   logic [31:0] ex_pc, ex_imm, ex_rs_data, ex_rt_data, ex_br_target;
   logic [4:0]  ex_rd_addr;
   logic [15:0] ex_ctrl, stall_cnt;

   logic        s_valid, s_wb_en;
   logic [31:0] s_pc, s_imm, s_rs, s_rt, s_br;
   logic [4:0]  s_rd;
   logic [15:0] s_ctrl;
   logic [3:0]  s_cnt;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   id_ex_reg #(.CTRL_W(16), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
      .id_pc(id_pc), .ZeroExt5_in(ze5), .ZeroExt16_in(ze16),
      .SignExt16_in(se16), .SignExt18_in(se18), .imm_sel(imm_sel),
      .rs_data(rs_data), .rt_data(rt_data), .rd_addr(rd_addr), .wb_en(wb_en),
      .ctrl(ctrl), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
      .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
      .ex_rd_addr(ex_rd_addr), .ex_wb_en(ex_wb_en), .ex_ctrl(ex_ctrl),
      .ex_br_target(ex_br_target), .stall_cnt(stall_cnt)
   );

   // Narrow-counter instance for the saturation corner.
   id_ex_reg #(.CTRL_W(16), .CNT_W(4)) dut_small (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
      .id_pc(id_pc), .ZeroExt5_in(ze5), .ZeroExt16_in(ze16),
      .SignExt16_in(se16), .SignExt18_in(se18), .imm_sel(imm_sel),
      .rs_data(rs_data), .rt_data(rt_data), .rd_addr(rd_addr), .wb_en(wb_en),
      .ctrl(ctrl), .ex_valid(s_valid), .ex_pc(s_pc), .ex_imm(s_imm),
      .ex_rs_data(s_rs), .ex_rt_data(s_rt), .ex_rd_addr(s_rd),
      .ex_wb_en(s_wb_en), .ex_ctrl(s_ctrl), .ex_br_target(s_br),
      .stall_cnt(s_cnt)
   );

   function automatic logic [31:0] br_of(logic [31:0] pc, logic [31:0] t18);
      return BR_EN ? (pc + 32'd4 + t18) : 32'd0;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic check_out(string tag, out_t e);
      chk({tag, ".ex_valid"},     32'(ex_valid),   32'(e.valid));
      chk({tag, ".ex_wb_en"},     32'(ex_wb_en),   32'(e.wb));
      chk({tag, ".ex_pc"},        ex_pc,           e.pc);
      chk({tag, ".ex_imm"},       ex_imm,          e.imm);
      chk({tag, ".ex_rs_data"},   ex_rs_data,      e.rs);
      chk({tag, ".ex_rt_data"},   ex_rt_data,      e.rt);
      chk({tag, ".ex_rd_addr"},   32'(ex_rd_addr), 32'(e.rd));
      chk({tag, ".ex_ctrl"},      32'(ex_ctrl),    32'(e.ctrl));
      chk({tag, ".ex_br_target"}, ex_br_target,    e.br);
      chk({tag, ".stall_cnt"},    32'(stall_cnt),  32'(e.cnt));
   endtask

   task automatic apply(in_t x);
      stall = x.stall;  flush = x.flush;  id_valid = x.id_valid;
      wb_en = x.wb_en;  imm_sel = x.imm_sel; id_pc = x.id_pc;
      ze5 = x.ze5; ze16 = x.ze16; se16 = x.se16; se18 = x.se18;
      rs_data = x.rs; rt_data = x.rt; rd_addr = x.rd; ctrl = x.ctrl;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[7];
   out_t zero_o, hold_o, e;
   in_t  base, x;

   initial begin
      zero_o = '{1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 16'd0, 32'd0, 16'd0};
      base = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 32'h0040_0010, 32'h0000_001F,
               32'h0000_1234, 32'hFFFF_8000, 32'hFFFE_0000, 32'h1111_1111,
               32'h2222_2222, 5'd5, 16'h1357};

      // {inputs} , {expected outputs one edge later}
      vecs[0].i = base;
      vecs[0].o = '{1'b1, 1'b1, 32'h0040_0010, 32'hFFFF_8000, 32'h1111_1111,
                    32'h2222_2222, 5'd5, 16'h1357, br_of(32'h0040_0010, 32'hFFFE_0000), 16'd0};
      vecs[1].i = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0000_1000, 32'h0000_0013,
                    32'h0000_BEEF, 32'h0000_7FFF, 32'h0001_FFFC, 32'hA5A5_A5A5,
                    32'h5A5A_5A5A, 5'd31, 16'h00FF};
      vecs[1].o = '{1'b1, 1'b0, 32'h0000_1000, 32'h0000_0013, 32'hA5A5_A5A5,
                    32'h5A5A_5A5A, 5'd31, 16'h00FF, br_of(32'h0000_1000, 32'h0001_FFFC), 16'd0};
      vecs[2].i = vecs[1].i; vecs[2].i.imm_sel = 2'b01; vecs[2].i.wb_en = 1'b1;
      vecs[2].o = vecs[1].o; vecs[2].o.imm = 32'h0000_BEEF; vecs[2].o.wb = 1'b1;
      vecs[3].i = vecs[1].i; vecs[3].i.imm_sel = 2'b11;
      vecs[3].o = vecs[1].o; vecs[3].o.imm = 32'h0001_FFFC;
      // id_valid=0 gates wb_en and ctrl but other fields still copy
      vecs[4].i = base; vecs[4].i.id_valid = 1'b0; vecs[4].i.ctrl = 16'hABCD;
      vecs[4].o = vecs[0].o; vecs[4].o.valid = 1'b0; vecs[4].o.wb = 1'b0;
      vecs[4].o.ctrl = 16'h0000;
      // stall+flush: bubble wins and the counter does not move
      vecs[5].i = base; vecs[5].i.stall = 1'b1; vecs[5].i.flush = 1'b1;
      vecs[5].o = zero_o;
      vecs[6].i = base;
      vecs[6].o = vecs[0].o;

      // 1: reset with every input nonzero (stall high too), two edges
      x = base; x.stall = 1'b1;
      apply(x);
      rst = 1'b1;
      step(); step();
      check_out("reset", zero_o);
      chk("reset.small_cnt", 32'(s_cnt), 32'd0);
      rst = 1'b0;

      for (int k = 0; k < 7; k++) begin
         apply(vecs[k].i);
         step();
         check_out($sformatf("vec%0d", k), vecs[k].o);
      end

      // 3: stall three edges while ID inputs change; ex_* hold
      hold_o = vecs[6].o;
      for (int k = 1; k <= 3; k++) begin
         x = vecs[1].i; x.stall = 1'b1; x.id_pc = 32'(k * 16);
         apply(x);
         step();
         e = hold_o; e.cnt = 16'(k);
         check_out($sformatf("stall%0d", k), e);
      end

      // reset during stall wins; next edge loads normally
      rst = 1'b1;
      step();
      check_out("rst_mid_stall", zero_o);
      rst = 1'b0;
      apply(vecs[1].i);
      step();
      check_out("post_rst_load", vecs[1].o);

      // 5: stall held 20 edges; 4-bit counter saturates at 15
      x = vecs[1].i; x.stall = 1'b1;
      apply(x);
      for (int k = 1; k <= 20; k++) begin
         step();
         chk($sformatf("sat%0d.small_cnt", k), 32'(s_cnt), (k > 15) ? 32'd15 : 32'(k));
         chk($sformatf("sat%0d.stall_cnt", k), 32'(stall_cnt), 32'(k));
      end
      chk("sat.ex_pc_held", ex_pc, 32'h0000_1000);

      // plain flush after saturation: bubble, counters untouched
      x.flush = 1'b1; x.stall = 1'b0;
      apply(x);
      step();
      e = zero_o; e.cnt = 16'd20;
      check_out("flush", e);
      chk("flush.small_cnt", 32'(s_cnt), 32'd15);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
